alu_share_arb: RTL
==================

// Module: alu_share_arb
// PURPOSE
//  Shares one combinational 32-bit ALU (AND/OR/XOR/XNOR/ADD/SUB/SLT/SLL, 3-bit op) between two requesters.
//  Arbitrates round-robin, registers operands, captures F/ZF/OF and returns them on a valid/ready response
//  channel tagged with the requester ID. Sits between the control units and the shared ALU.
// PARAMETERS
//  DW        32  operand/result width; fixed at 32 to match the ALU
//  RR_EN     1   1 = round-robin, 0 = fixed priority (port 0 wins)
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  req0_valid  in   1   requester 0 has an op
//  req0_ready  out  1   requester 0 op accepted this cycle (when valid&ready)
//  req0_op     in   3   ALU op code
//  req0_a      in   DW  operand A
//  req0_b      in   DW  operand B
//  req1_*      -    -   same set as req0_* for requester 1
//  rsp_valid   out  1   result available
//  rsp_ready   in   1   consumer takes result (when valid&ready)
//  rsp_id      out  1   requester that issued the op
//  rsp_f       out  DW  ALU result F
//  rsp_zf      out  1   zero flag (F==0)
//  rsp_of      out  1   ALU OF output as produced
//  ops_done    out  16  count of completed responses, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (port 0 first), req*_ready=0, rsp_valid=0, rsp_id=0, rsp_f=0,
//   rsp_zf=0, rsp_of=0, ops_done=0. Reset in EXEC or RESP drops the op; no response is issued.
//  FSM: IDLE -> EXEC when any reqX_valid; EXEC -> RESP unconditionally; RESP -> IDLE on rsp_ready.
//  IDLE: grant = only valid port; both valid -> port rr_ptr (RR_EN=1) or port 0 (RR_EN=0).
//   reqX_ready = (state==IDLE) & grantX; combinational from valids, at most one high; 0 in EXEC/RESP.
//   On accept: latch op/a/b/id into op_q/a_q/b_q/id_q; rr_ptr <= ~granted id.
//  EXEC: ALU driven from op_q/a_q/b_q; F, ZF, OF captured into rsp_* regs at end of cycle.
//  RESP: rsp_valid=1; rsp_* held stable until rsp_ready; on handshake rsp_valid<=0, ops_done++.
//  Latency: accept at cycle N -> rsp_valid high at N+2. Throughput 1 op / 3 cycles with rsp_ready=1.
//  No bypass: a request presented in RESP waits; IDLE->accept is the earliest cycle after RESP ends.
//  reqX_valid dropped before accept is legal (no op, no state change). Operands read only at accept.
//  Widths: ALU results truncated to DW; ZF = ~|F; SLT yields 32'h0/32'h1; SLL shift = A.
//  rsp_ready while rsp_valid=0 has no effect. ops_done wraps silently.
// STRUCTURE
//  Shared package alu_pkg: localparams ALU_AND=3'b000 .. ALU_SLL=3'b111, DW=32,
//   FSM encoding S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2.
//  One sub-module: alu_core (combinational ALU, ports A,B,ALU_OP,F,ZF,OF); arbiter+FSM inline.
// TESTING
//  1 single: req0 ADD a=5 b=7 -> ready same cycle, 2 cycles later rsp_f=12, zf=0, id=0, ops_done=1.
//  2 contention: both valid from reset, 4 ops each -> rsp_id 0,1,0,1..; with RR_EN=0 all port-0 first.
//  3 flags: SUB a=9 b=9 -> f=0, zf=1; ADD 7FFFFFFF+1 -> f=80000000, of=ALU OF; SLT 3<4 -> f=1.
//  4 backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req*_ready=0; release -> 1 handshake.
//  5 reset mid-op: rst in EXEC -> next cycle rsp_valid=0, state IDLE, ops_done=0, rr_ptr=0.
//  6 wrap: preload 65535 completions (or force) then 1 op -> ops_done=0; SLL a=4 b=1 -> f=16.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared-ALU arbiter slice: datapath width, ALU
// op codes and the arbiter FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    // Operand/result width; fixed to match the ALU datapath.
    localparam int DW = 32;

    // 3-bit ALU op codes.
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_XNOR = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    // Arbiter FSM: accept in IDLE, compute in EXEC, present result in RESP.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// -----------------------------------------------------------------------------
// alu_share_arb_if
// Bundles the two request channels, the response channel and the completion
// counter of alu_share_arb.
//   master : requesters + response consumer (drives req*_valid/op/a/b, rsp_ready)
//   slave  : the arbiter (drives req*_ready, rsp_*, ops_done)
// -----------------------------------------------------------------------------
interface alu_share_arb_if;
    import alu_pkg::*;

    logic          req0_valid;
    logic          req0_ready;
    logic [2:0]    req0_op;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;

    logic          req1_valid;
    logic          req1_ready;
    logic [2:0]    req1_op;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_f;
    logic          rsp_zf;
    logic          rsp_of;

    logic [15:0]   ops_done;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of, ops_done
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of, ops_done
    );

endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational 32-bit ALU.
//   A, B    in  DW  operands
//   ALU_OP  in  3   op code (alu_pkg::ALU_*)
//   F       out DW  result, truncated to DW
//   ZF      out 1   F == 0
//   OF      out 1   signed overflow for ADD/SUB, 0 for every other op
// SLT is a signed compare yielding 0/1; SLL shifts B left by A.
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [2:0]    ALU_OP,
    output logic [DW-1:0] F,
    output logic          ZF,
    output logic          OF
);

    logic [DW-1:0] sum;
    logic [DW-1:0] diff;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned and infers a latch.
        F  = '0;
        OF = 1'b0;
        case (ALU_OP)
            ALU_AND:  F = A & B;
            ALU_OR:   F = A | B;
            ALU_XOR:  F = A ^ B;
            ALU_XNOR: F = ~(A ^ B);
            ALU_ADD: begin
                F  = sum;
                // Same-sign operands producing an opposite-sign sum.
                OF = (A[DW-1] == B[DW-1]) && (sum[DW-1] != A[DW-1]);
            end
            ALU_SUB: begin
                F  = diff;
                // Opposite-sign operands where the difference takes B's sign.
                OF = (A[DW-1] != B[DW-1]) && (diff[DW-1] != A[DW-1]);
            end
            ALU_SLT:  F = {{(DW-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLL:  F = B << A;
            default:  F = '0;
        endcase
    end

    assign ZF = ~|F;

endmodule

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Shares one alu_core between two requesters. A request is accepted in IDLE,
// its operands registered, the ALU evaluated from the registers in EXEC and the
// F/ZF/OF result held on the response channel in RESP until taken.
// Accept at cycle N -> rsp_valid at N+2; at most one op in flight.
//   clk, rst   single clock, synchronous active-high reset
//   bus        alu_share_arb_if.slave: req0_*/req1_* request channels,
//              rsp_* response channel tagged with rsp_id, ops_done counter
// Parameter RR_EN: 1 = round-robin between contending ports, 0 = port 0 wins.
// -----------------------------------------------------------------------------
module alu_share_arb
    import alu_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    alu_share_arb_if.slave bus
);

    state_t        state;
    logic          rr_ptr;     // port that wins the next contended grant

    logic [2:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          id_q;

    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [DW-1:0] rsp_f_q;
    logic          rsp_zf_q;
    logic          rsp_of_q;
    logic [15:0]   done_cnt;

    logic          any_valid;
    logic          grant_id;
    logic          accept;

    logic [DW-1:0] alu_f;
    logic          alu_zf;
    logic          alu_of;

    // Arbitration: a lone valid port always wins; contention is settled by
    // rr_ptr or, with round-robin disabled, in favour of port 0.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant_id  = (bus.req0_valid && bus.req1_valid) ? (RR_EN ? rr_ptr : 1'b0)
                                                          : bus.req1_valid;
    assign accept    = (state == S_IDLE) && any_valid;

    assign bus.req0_ready = accept & ~grant_id;
    assign bus.req1_ready = accept &  grant_id;

    alu_core u_alu (
        .A      (a_q),
        .B      (b_q),
        .ALU_OP (op_q),
        .F      (alu_f),
        .ZF     (alu_zf),
        .OF     (alu_of)
    );

    // NOTE: the captured operands carry no reset; they are always written on accept before EXEC reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= grant_id ? bus.req1_op : bus.req0_op;
            a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
            b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
            id_q <= grant_id;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_f_q     <= '0;
            rsp_zf_q    <= 1'b0;
            rsp_of_q    <= 1'b0;
            done_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        rr_ptr <= ~grant_id;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_f_q     <= alu_f;
                    rsp_zf_q    <= alu_zf;
                    rsp_of_q    <= alu_of;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        done_cnt    <= done_cnt + 16'd1;   // wraps silently
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_f     = rsp_f_q;
    assign bus.rsp_zf    = rsp_zf_q;
    assign bus.rsp_of    = rsp_of_q;
    assign bus.ops_done  = done_cnt;

endmodule
